// File: rtl/sha_round_sequencer.sv
// Moore control sequencer for one SHA-256 compression core: IV load, message fetch
// handshake, round stepping, H accumulation and working-variable reload over 1..MAX_BLOCKS blocks.
module sha_round_sequencer #(
    parameter int ROUNDS     = 64,
    parameter int MAX_BLOCKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] num_blocks,
    input  logic       abort,
    input  logic       msg_ack,
    output logic       busy,
    output logic       done,
    output logic [1:0] block_idx,
    output logic [5:0] round_idx,
    output logic       init_h,
    output logic       msg_req,
    output logic       round_en,
    output logic       accum_en,
    output logic       wv_load
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MSG_REQ,
        S_ROUND,
        S_ACCUM,
        S_WV_LOAD,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [1:0] MAX_COUNT  = 2'(MAX_BLOCKS);

    state_t     state_q, state_d;
    logic [1:0] block_idx_q, block_idx_d;
    logic [1:0] count_q, count_d;
    logic [5:0] round_idx_q, round_idx_d;

    logic start_ok;
    logic more_blocks;

    assign start_ok    = start && !abort && (num_blocks != 2'd0) && (num_blocks <= MAX_COUNT);
    // Widened by one bit so block_idx+1 cannot alias back to a small value.
    assign more_blocks = ({1'b0, block_idx_q} + 3'd1) < {1'b0, count_q};

    always_comb begin
        state_d     = state_q;
        block_idx_d = block_idx_q;
        count_d     = count_q;
        round_idx_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d     = S_INIT;
                    count_d     = num_blocks;
                    block_idx_d = 2'd0;
                end
            end
            S_INIT: begin
                state_d = S_MSG_REQ;
            end
            S_MSG_REQ: begin
                if (msg_ack) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (round_idx_q == LAST_ROUND) begin
                    state_d = S_ACCUM;
                end else begin
                    round_idx_d = round_idx_q + 6'd1;
                end
            end
            S_ACCUM: begin
                if (more_blocks) begin
                    block_idx_d = block_idx_q + 2'd1;
                    state_d     = S_WV_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WV_LOAD: begin
                state_d = S_MSG_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition, including a pending block increment.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            block_idx_d = block_idx_q;
            count_d     = count_q;
            round_idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            block_idx_q <= 2'd0;
            count_q     <= 2'd0;
            round_idx_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            block_idx_q <= block_idx_d;
            count_q     <= count_d;
            round_idx_q <= round_idx_d;
        end
    end

    // round_idx_q is zero outside ROUND, so it can drive the port directly.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign init_h    = (state_q == S_INIT);
    assign msg_req   = (state_q == S_MSG_REQ);
    assign round_en  = (state_q == S_ROUND);
    assign accum_en  = (state_q == S_ACCUM);
    assign wv_load   = (state_q == S_WV_LOAD);
    assign block_idx = block_idx_q;
    assign round_idx = round_idx_q;

endmodule
